// File: rtl/bus.sv
// Single-cycle interconnect: fixed-priority host arbitration, mask/base device decode,
// zero-latency request forwarding and one-cycle registered response routing.

module bus_dev_port #(
  parameter int DataWidth    = 32,
  parameter int AddressWidth = 32
) (
  input  logic                    sel_i,
  input  logic [AddressWidth-1:0] addr_i,
  input  logic [AddressWidth-1:0] base_i,
  input  logic [AddressWidth-1:0] mask_i,
  input  logic                    we_i,
  input  logic [DataWidth/8-1:0]  be_i,
  input  logic [DataWidth-1:0]    wdata_i,
  output logic                    hit_o,
  output logic                    req_o,
  output logic [AddressWidth-1:0] addr_o,
  output logic                    we_o,
  output logic [DataWidth/8-1:0]  be_o,
  output logic [DataWidth-1:0]    wdata_o
);
  assign hit_o   = (addr_i & mask_i) == base_i;
  // Unselected devices see an all-zero request, not a copy of the bus.
  assign req_o   = sel_i;
  assign addr_o  = sel_i ? addr_i  : '0;
  assign we_o    = sel_i ? we_i    : 1'b0;
  assign be_o    = sel_i ? be_i    : '0;
  assign wdata_o = sel_i ? wdata_i : '0;
endmodule

module bus_host_port #(
  parameter int DataWidth = 32
) (
  input  logic                 gnt_i,
  input  logic                 rsp_sel_i,
  input  logic                 unmapped_i,
  input  logic                 dev_rvalid_i,
  input  logic [DataWidth-1:0] dev_rdata_i,
  input  logic                 dev_err_i,
  output logic                 gnt_o,
  output logic                 rvalid_o,
  output logic [DataWidth-1:0] rdata_o,
  output logic                 err_o
);
  assign gnt_o = gnt_i;

  always_comb begin
    rvalid_o = 1'b0;
    rdata_o  = '0;
    err_o    = 1'b0;
    if (rsp_sel_i) begin
      if (unmapped_i) begin
        rvalid_o = 1'b1;
        err_o    = 1'b1;
      end else if (dev_rvalid_i) begin
        rvalid_o = 1'b1;
        rdata_o  = dev_rdata_i;
        err_o    = dev_err_i;
      end
    end
  end
endmodule

module bus #(
  parameter int NrDevices    = 1,
  parameter int NrHosts      = 1,
  parameter int DataWidth    = 32,
  parameter int AddressWidth = 32
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  input  logic [NrHosts-1:0]                     host_req_i,
  output logic [NrHosts-1:0]                     host_gnt_o,
  input  logic [NrHosts-1:0][AddressWidth-1:0]   host_addr_i,
  input  logic [NrHosts-1:0]                     host_we_i,
  input  logic [NrHosts-1:0][DataWidth/8-1:0]    host_be_i,
  input  logic [NrHosts-1:0][DataWidth-1:0]      host_wdata_i,
  output logic [NrHosts-1:0]                     host_rvalid_o,
  output logic [NrHosts-1:0][DataWidth-1:0]      host_rdata_o,
  output logic [NrHosts-1:0]                     host_err_o,
  output logic [NrDevices-1:0]                   device_req_o,
  output logic [NrDevices-1:0][AddressWidth-1:0] device_addr_o,
  output logic [NrDevices-1:0]                   device_we_o,
  output logic [NrDevices-1:0][DataWidth/8-1:0]  device_be_o,
  output logic [NrDevices-1:0][DataWidth-1:0]    device_wdata_o,
  input  logic [NrDevices-1:0]                   device_rvalid_i,
  input  logic [NrDevices-1:0][DataWidth-1:0]    device_rdata_i,
  input  logic [NrDevices-1:0]                   device_err_i,
  input  logic [NrDevices-1:0][AddressWidth-1:0] cfg_device_addr_base,
  input  logic [NrDevices-1:0][AddressWidth-1:0] cfg_device_addr_mask
);
  localparam int HostIdxW = (NrHosts > 1) ? $clog2(NrHosts) : 1;
  localparam int DevIdxW  = (NrDevices > 1) ? $clog2(NrDevices) : 1;
  localparam int BeW      = DataWidth / 8;

  typedef struct packed {
    logic [AddressWidth-1:0] addr;
    logic                    we;
    logic [BeW-1:0]          be;
    logic [DataWidth-1:0]    wdata;
  } req_t;

  typedef struct packed {
    logic                vld;
    logic [HostIdxW-1:0] host;
    logic [DevIdxW-1:0]  dev;
    logic                unmapped;
  } rsp_sel_t;

  logic                 any_req;
  logic [HostIdxW-1:0]  win_idx;
  req_t                 win_req;
  logic [NrDevices-1:0] dev_hit;
  logic                 hit_any;
  logic [DevIdxW-1:0]   dev_idx;
  logic                 fwd_en;
  rsp_sel_t             rsp_d, rsp_q;

  // Descending scan: the last assignment, i.e. the lowest requesting index, wins.
  always_comb begin
    any_req = 1'b0;
    win_idx = '0;
    for (int h = NrHosts - 1; h >= 0; h--) begin
      if (host_req_i[h]) begin
        any_req = 1'b1;
        win_idx = HostIdxW'(h);
      end
    end
  end

  assign win_req.addr  = host_addr_i[win_idx];
  assign win_req.we    = host_we_i[win_idx];
  assign win_req.be    = host_be_i[win_idx];
  assign win_req.wdata = host_wdata_i[win_idx];

  always_comb begin
    hit_any = 1'b0;
    dev_idx = '0;
    for (int d = NrDevices - 1; d >= 0; d--) begin
      if (dev_hit[d]) begin
        hit_any = 1'b1;
        dev_idx = DevIdxW'(d);
      end
    end
  end

  assign fwd_en = any_req & hit_any & ~rst_i;

  generate
    for (genvar d = 0; d < NrDevices; d++) begin : g_dev
      localparam logic [DevIdxW-1:0] Idx = DevIdxW'(d);
      bus_dev_port #(
        .DataWidth   (DataWidth),
        .AddressWidth(AddressWidth)
      ) u_dev_port (
        .sel_i  (fwd_en && (dev_idx == Idx)),
        .addr_i (win_req.addr),
        .base_i (cfg_device_addr_base[d]),
        .mask_i (cfg_device_addr_mask[d]),
        .we_i   (win_req.we),
        .be_i   (win_req.be),
        .wdata_i(win_req.wdata),
        .hit_o  (dev_hit[d]),
        .req_o  (device_req_o[d]),
        .addr_o (device_addr_o[d]),
        .we_o   (device_we_o[d]),
        .be_o   (device_be_o[d]),
        .wdata_o(device_wdata_o[d])
      );
    end
  endgenerate

  // Routing info is captured only on granted cycles; vld marks a pending response.
  always_comb begin
    rsp_d     = rsp_q;
    rsp_d.vld = any_req;
    if (any_req) begin
      rsp_d.host     = win_idx;
      rsp_d.dev      = dev_idx;
      rsp_d.unmapped = ~hit_any;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) rsp_q <= '0;
    else       rsp_q <= rsp_d;
  end

  generate
    for (genvar h = 0; h < NrHosts; h++) begin : g_host
      localparam logic [HostIdxW-1:0] Idx = HostIdxW'(h);
      bus_host_port #(
        .DataWidth(DataWidth)
      ) u_host_port (
        .gnt_i       (any_req && ~rst_i && (win_idx == Idx)),
        .rsp_sel_i   (rsp_q.vld && ~rst_i && (rsp_q.host == Idx)),
        .unmapped_i  (rsp_q.unmapped),
        .dev_rvalid_i(device_rvalid_i[rsp_q.dev]),
        .dev_rdata_i (device_rdata_i[rsp_q.dev]),
        .dev_err_i   (device_err_i[rsp_q.dev]),
        .gnt_o       (host_gnt_o[h]),
        .rvalid_o    (host_rvalid_o[h]),
        .rdata_o     (host_rdata_o[h]),
        .err_o       (host_err_o[h])
      );
    end
  endgenerate
endmodule

// File: tb/tb_bus.sv
// Bench for bus: vector table for grant/decode/forwarding, scoreboard queue for responses,
// hand-written reset sequences.

module tb_bus;
  localparam int NH = 2, ND = 3, DW = 32, AW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                   rst;
  logic [NH-1:0]          host_req, host_gnt, host_we, host_rvalid, host_err;
  logic [NH-1:0][AW-1:0]  host_addr;
  logic [NH-1:0][3:0]     host_be;
  logic [NH-1:0][DW-1:0]  host_wdata, host_rdata;
  logic [ND-1:0]          dev_req, dev_we, dev_rvalid, dev_err;
  logic [ND-1:0][AW-1:0]  dev_addr, cfg_base, cfg_mask;
  logic [ND-1:0][3:0]     dev_be;
  logic [ND-1:0][DW-1:0]  dev_wdata, dev_rdata;

  bus #(.NrDevices(ND), .NrHosts(NH), .DataWidth(DW), .AddressWidth(AW)) dut (
    .clk_i(clk), .rst_i(rst),
    .host_req_i(host_req), .host_gnt_o(host_gnt), .host_addr_i(host_addr),
    .host_we_i(host_we), .host_be_i(host_be), .host_wdata_i(host_wdata),
    .host_rvalid_o(host_rvalid), .host_rdata_o(host_rdata), .host_err_o(host_err),
    .device_req_o(dev_req), .device_addr_o(dev_addr), .device_we_o(dev_we),
    .device_be_o(dev_be), .device_wdata_o(dev_wdata),
    .device_rvalid_i(dev_rvalid), .device_rdata_i(dev_rdata), .device_err_i(dev_err),
    .cfg_device_addr_base(cfg_base), .cfg_device_addr_mask(cfg_mask)
  );

  // Device model: answers exactly one cycle after its request with the current vector's data.
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  always @(posedge clk) begin
    for (int d = 0; d < ND; d++) begin
      dev_rvalid[d] <= dev_req[d];
      dev_rdata[d]  <= dev_req[d] ? rsp_rdata : '0;
      dev_err[d]    <= dev_req[d] & rsp_err;
    end
  end

  typedef struct {
    logic [1:0]  req;
    logic [31:0] a0, a1;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wd, rd;
    logic        rerr;
    logic [1:0]  gnt;
    logic [2:0]  dreq;
  } vec_t;

  typedef struct {
    int          host;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  localparam int NV = 12;
  vec_t v[NV];
  exp_t sbq[$];
  int checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic check_rsp();
    exp_t e;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      chk("rsp_rvalid", 32'(host_rvalid), 32'(1 << e.host));
      chk("rsp_rdata", host_rdata[e.host], e.rdata);
      chk("rsp_err", 32'(host_err), 32'(e.err) << e.host);
      chk("rsp_other_rdata", host_rdata[1 - e.host], 32'h0);
    end else begin
      chk("idle_rvalid", 32'(host_rvalid), 32'h0);
      chk("idle_err", 32'(host_err), 32'h0);
      chk("idle_rdata", host_rdata[0] | host_rdata[1], 32'h0);
    end
  endtask

  task automatic check_all_zero(input string nm);
    chk({nm, "_gnt"}, 32'(host_gnt), 32'h0);
    chk({nm, "_dreq"}, 32'(dev_req), 32'h0);
    chk({nm, "_rvalid"}, 32'(host_rvalid), 32'h0);
    chk({nm, "_err"}, 32'(host_err), 32'h0);
    chk({nm, "_rdata"}, host_rdata[0] | host_rdata[1], 32'h0);
    chk({nm, "_daddr"}, dev_addr[0] | dev_addr[1] | dev_addr[2], 32'h0);
  endtask

  task automatic drive(input logic [1:0] req, input logic [31:0] a0, input logic [31:0] a1,
                       input logic we, input logic [3:0] be, input logic [31:0] wd,
                       input logic [31:0] rd, input logic rerr);
    host_req = req;
    host_addr[0] = a0;  host_addr[1] = a1;
    host_we = {we, we};
    host_be[0] = be;    host_be[1] = be;
    host_wdata[0] = wd; host_wdata[1] = wd;
    rsp_rdata = rd;
    rsp_err = rerr;
  endtask

  initial begin
    exp_t        e;
    logic [31:0] waddr;
    cfg_base[0] = 32'h0010_0000; cfg_mask[0] = ~32'h000F_FFFF;
    cfg_base[1] = 32'h0002_0000; cfg_mask[1] = ~32'h0000_03FF;
    cfg_base[2] = 32'h0003_0000; cfg_mask[2] = ~32'h0000_03FF;
    //        req    a0            a1            we    be     wd      rd            rerr  gnt    dreq
    v[0]  = '{2'b00, 32'h0,        32'h0,        1'b0, 4'h0, 32'h0,  32'h0,        1'b0, 2'b00, 3'b000};
    v[1]  = '{2'b01, 32'h100040,   32'h0,        1'b0, 4'hF, 32'h0,  32'hDEADBEEF, 1'b0, 2'b01, 3'b001};
    v[2]  = '{2'b01, 32'h20000,    32'h0,        1'b1, 4'h1, 32'h41, 32'h0,        1'b0, 2'b01, 3'b010};
    v[3]  = '{2'b11, 32'h30004,    32'h100000,   1'b0, 4'hF, 32'h0,  32'h3333,     1'b0, 2'b01, 3'b100};
    v[4]  = '{2'b10, 32'h0,        32'h100000,   1'b0, 4'hF, 32'h0,  32'h1111,     1'b0, 2'b10, 3'b001};
    v[5]  = '{2'b01, 32'h50000,    32'h0,        1'b0, 4'hF, 32'h0,  32'h9999,     1'b0, 2'b01, 3'b000};
    v[6]  = '{2'b01, 32'h30008,    32'h0,        1'b0, 4'hF, 32'h0,  32'hBAD,      1'b1, 2'b01, 3'b100};
    v[7]  = '{2'b01, 32'h100000,   32'h0,        1'b0, 4'hF, 32'h0,  32'hA1,       1'b0, 2'b01, 3'b001};
    v[8]  = '{2'b01, 32'h100004,   32'h0,        1'b0, 4'hF, 32'h0,  32'hA2,       1'b0, 2'b01, 3'b001};
    v[9]  = '{2'b10, 32'h0,        32'h203FC,    1'b1, 4'hC, 32'h77, 32'h55,       1'b0, 2'b10, 3'b010};
    v[10] = '{2'b10, 32'h0,        32'h20400,    1'b0, 4'hF, 32'h0,  32'h66,       1'b0, 2'b10, 3'b000};
    v[11] = '{2'b00, 32'h0,        32'h0,        1'b0, 4'h0, 32'h0,  32'h0,        1'b0, 2'b00, 3'b000};

    // Reset with both hosts requesting: everything must stay quiet.
    rst = 1'b1;
    drive(2'b11, 32'h100000, 32'h20000, 1'b1, 4'hF, 32'h1234, 32'h0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    drive(2'b00, 32'h0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);

    for (int i = 0; i < NV; i++) begin
      @(posedge clk); #1;
      drive(v[i].req, v[i].a0, v[i].a1, v[i].we, v[i].be, v[i].wd, v[i].rd, v[i].rerr);
      @(negedge clk);
      check_rsp();
      chk($sformatf("v%0d_gnt", i), 32'(host_gnt), 32'(v[i].gnt));
      chk($sformatf("v%0d_dreq", i), 32'(dev_req), 32'(v[i].dreq));
      waddr = v[i].gnt[1] ? v[i].a1 : v[i].a0;
      for (int d = 0; d < ND; d++) begin
        if (v[i].dreq[d]) begin
          chk($sformatf("v%0d_d%0d_addr", i, d), dev_addr[d], waddr);
          chk($sformatf("v%0d_d%0d_we", i, d), 32'(dev_we[d]), 32'(v[i].we));
          chk($sformatf("v%0d_d%0d_be", i, d), 32'(dev_be[d]), 32'(v[i].be));
          chk($sformatf("v%0d_d%0d_wdata", i, d), dev_wdata[d], v[i].wd);
        end else begin
          chk($sformatf("v%0d_d%0d_zero", i, d),
              dev_addr[d] | dev_wdata[d] | 32'(dev_be[d]) | 32'(dev_we[d]), 32'h0);
        end
      end
      if (v[i].gnt != 2'b00) begin
        e.host  = v[i].gnt[1] ? 1 : 0;
        e.rdata = (v[i].dreq == 3'b000) ? 32'h0 : v[i].rd;
        e.err   = (v[i].dreq == 3'b000) ? 1'b1 : v[i].rerr;
        sbq.push_back(e);
      end
    end
    chk("sb_drained", 32'(sbq.size()), 32'h0);

    // Reset on the cycle after a grant: the pending response must be dropped.
    @(posedge clk); #1;
    drive(2'b01, 32'h100000, 32'h0, 1'b0, 4'hF, 32'h0, 32'h77, 1'b0);
    @(negedge clk);
    chk("rstseq_gnt", 32'(host_gnt), 32'h1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("rstseq_a");
    @(posedge clk); #1;
    host_req = 2'b00;
    @(negedge clk);
    check_all_zero("rstseq_b");
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk($sformatf("post_rst_rvalid%0d", k), 32'(host_rvalid), 32'h0);
      @(posedge clk); #1;
    end

    // Fresh transaction after reset still works end to end.
    drive(2'b10, 32'h0, 32'h100008, 1'b0, 4'hF, 32'h0, 32'hC0FFEE, 1'b0);
    @(negedge clk);
    chk("post_rst_gnt", 32'(host_gnt), 32'h2);
    @(posedge clk); #1;
    drive(2'b00, 32'h0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    chk("post_rst_rsp_rvalid", 32'(host_rvalid), 32'h2);
    chk("post_rst_rsp_rdata", host_rdata[1], 32'hC0FFEE);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
